mem_access_unit: RTL and testbench

Initiator side of the synchronous 2-port Memory's read/write port (port 2), used by the LC-3b MEM stage. Accepts one load/store request at a time over a valid/ready handshake and drives the memory enable, address, byte-lane write strobes and write data. Returns formatted read data (word, or sign-extended byte) with a one-cycle response pulse. Flags unaligned word accesses without touching memory.

---
 rtl/mem_access_unit_pkg.sv | 16 +
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_lane_fmt.sv | 36 +++
 rtl/mem_access_unit.sv | 89 ++++++++
 tb/tb_mem_access_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage memory access unit: FSM encodings, access sizes,
// and the byte sign-extension helper.
package mem_access_unit_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  localparam logic SizeWord = 1'b0;
  localparam logic SizeByte = 1'b1;

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Load/store request and response channel between the MEM stage and the access unit.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );

endinterface

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting for a 16-bit memory port: store strobes and data replication,
// load lane select with sign extension.
module mem_lane_fmt
  import mem_access_unit_pkg::*;
(
  input  logic        byte_acc,
  input  logic        addr_lsb,
  input  logic        store_en,
  input  logic [15:0] wdata,
  input  logic [15:0] rdata,
  output logic        we_low,
  output logic        we_high,
  output logic [15:0] mem_wdata,
  output logic [15:0] load_data
);

  always_comb begin
    we_low    = 1'b0;
    we_high   = 1'b0;
    mem_wdata = wdata;
    load_data = rdata;
    if (byte_acc == SizeByte) begin
      // Both lanes carry the byte so either strobe writes the right value.
      mem_wdata = {wdata[7:0], wdata[7:0]};
      load_data = sext8(addr_lsb ? rdata[15:8] : rdata[7:0]);
      if (store_en) begin
        we_low  = ~addr_lsb;
        we_high = addr_lsb;
      end
    end else if (store_en) begin
      we_low  = 1'b1;
      we_high = 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for memory port 2: one load/store at a time, optional wait states,
// formatted read data and a misaligned-word fault with a one-cycle response pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus,
  output logic               mem_en,
  output logic [15:0]        mem_addr,
  output logic               mem_we_low,
  output logic               mem_we_high,
  output logic [15:0]        mem_wdata,
  input  logic [15:0]        mem_rdata
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [15:0] addr_q, wdata_q;
  logic        write_q, byte_q, fault_q;
  logic [3:0]  cnt_q;

  logic        accept, misaligned, store_en;
  logic [15:0] load_data;

  assign accept     = (state_q == StIdle) && bus.req_valid;
  assign misaligned = (bus.req_byte == SizeWord) && bus.req_addr[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = misaligned ? StResp : StAccess;
      StAccess: if (cnt_q == 4'd0) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        write_q <= bus.req_write;
        byte_q  <= bus.req_byte;
        fault_q <= misaligned;
        cnt_q   <= WaitInit;
      end else if ((state_q == StAccess) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Strobe only on the final access cycle so each store writes exactly once.
  assign store_en = (state_q == StAccess) && (cnt_q == 4'd0) && write_q;

  mem_lane_fmt u_lane_fmt (
    .byte_acc  (byte_q),
    .addr_lsb  (addr_q[0]),
    .store_en  (store_en),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .we_low    (mem_we_low),
    .we_high   (mem_we_high),
    .mem_wdata (mem_wdata),
    .load_data (load_data)
  );

  assign mem_en   = (state_q == StAccess);
  assign mem_addr = addr_q;

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_fault = (state_q == StResp) && fault_q;
  assign bus.resp_rdata = ((state_q == StResp) && !write_q && !fault_q) ? load_data : 16'h0000;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (0 and 3 wait cycles) each behind a simple
// registered RAM, checked against a word-array reference model of the load/store rules.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if if0 ();
  mem_access_unit_if if3 ();

  logic        t_valid, t_write, t_byte;
  logic [15:0] t_addr, t_wdata;
  int          sel;

  assign if0.req_valid = t_valid && (sel == 0);
  assign if3.req_valid = t_valid && (sel == 1);
  assign if0.req_write = t_write;
  assign if3.req_write = t_write;
  assign if0.req_byte  = t_byte;
  assign if3.req_byte  = t_byte;
  assign if0.req_addr  = t_addr;
  assign if3.req_addr  = t_addr;
  assign if0.req_wdata = t_wdata;
  assign if3.req_wdata = t_wdata;

  logic        en0, wl0, wh0, en3, wl3, wh3;
  logic [15:0] addr0, wd0, rd0, addr3, wd3, rd3;

  mem_access_unit #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .mem_en(en0), .mem_addr(addr0),
    .mem_we_low(wl0), .mem_we_high(wh0), .mem_wdata(wd0), .mem_rdata(rd0)
  );

  mem_access_unit #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3), .mem_en(en3), .mem_addr(addr3),
    .mem_we_low(wl3), .mem_we_high(wh3), .mem_wdata(wd3), .mem_rdata(rd3)
  );

  // Registered-read RAMs, preloaded so the word at byte address a holds a.
  logic [15:0] mem0 [32768];
  logic [15:0] mem3 [32768];
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 32768; i++) begin
        mem0[i] <= 16'(i * 2);
        mem3[i] <= 16'(i * 2);
      end
      loaded <= 1'b1;
      rd0    <= 16'h0000;
      rd3    <= 16'h0000;
    end else begin
      if (en0) begin
        rd0 <= mem0[addr0[15:1]];
        if (wl0) mem0[addr0[15:1]][7:0]  <= wd0[7:0];
        if (wh0) mem0[addr0[15:1]][15:8] <= wd0[15:8];
      end else begin
        rd0 <= 16'h0000;
      end
      if (en3) begin
        rd3 <= mem3[addr3[15:1]];
        if (wl3) mem3[addr3[15:1]][7:0]  <= wd3[7:0];
        if (wh3) mem3[addr3[15:1]][15:8] <= wd3[15:8];
      end else begin
        rd3 <= 16'h0000;
      end
    end
  end

  logic        o_en, o_wl, o_wh, o_rv, o_rf, o_rdy;
  logic [15:0] o_wd, o_rd, o_addr;

  always_comb begin
    if (sel == 0) begin
      o_en = en0; o_wl = wl0; o_wh = wh0; o_wd = wd0; o_addr = addr0;
      o_rv = if0.resp_valid; o_rf = if0.resp_fault; o_rd = if0.resp_rdata; o_rdy = if0.req_ready;
    end else begin
      o_en = en3; o_wl = wl3; o_wh = wh3; o_wd = wd3; o_addr = addr3;
      o_rv = if3.resp_valid; o_rf = if3.resp_fault; o_rd = if3.resp_rdata; o_rdy = if3.req_ready;
    end
  end

  logic [15:0] refm [2][32768];
  int errors = 0;
  int checks = 0;

  int          lat, en_n, stb_n, stb_k;
  logic [15:0] rd, wd, sa;
  logic        flt, lo, hi, ra;

  // Reference: word array updated by the byte/word store rules; returns the expected rdata.
  function automatic logic [15:0] model_apply(input int d, input logic wr, input logic by,
                                              input logic [15:0] a, input logic [15:0] dat);
    logic [15:0] w;
    logic [7:0]  b;
    if (!by && a[0]) return 16'h0000;
    w = refm[d][a[15:1]];
    if (wr) begin
      if (!by)      refm[d][a[15:1]] = dat;
      else if (a[0]) refm[d][a[15:1]] = {dat[7:0], w[7:0]};
      else          refm[d][a[15:1]] = {w[15:8], dat[7:0]};
      return 16'h0000;
    end
    if (!by) return w;
    b = a[0] ? w[15:8] : w[7:0];
    return {{8{b[7]}}, b};
  endfunction

  // Called at a negedge with the selected unit idle; returns at a negedge.
  task automatic do_req(input logic wr, input logic by, input logic [15:0] a,
                        input logic [15:0] dat);
    lat = 0; en_n = 0; stb_n = 0; stb_k = 0;
    rd = 16'hxxxx; wd = 16'h0; sa = 16'h0; flt = 1'bx; lo = 1'b0; hi = 1'b0; ra = 1'b0;
    t_write = wr; t_byte = by; t_addr = a; t_wdata = dat; t_valid = 1'b1;
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    t_write = 1'($urandom); t_byte = 1'($urandom);
    t_addr = 16'($urandom); t_wdata = 16'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_en) en_n++;
      if (o_wl || o_wh) begin
        stb_n++; stb_k = k; lo = o_wl; hi = o_wh; wd = o_wd; sa = o_addr;
      end
      if (o_rv) begin
        lat = k; rd = o_rd; flt = o_rf;
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      ra = o_rdy;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; t_valid = 1'b0; t_write = 1'b0; t_byte = 1'b0;
    t_addr = 16'h0; t_wdata = 16'h0; sel = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d;
      #1;
      checks++;
      if (o_rdy !== 1'b1 || o_rv !== 1'b0 || o_rf !== 1'b0 || o_rd !== 16'h0) begin
        errors++;
        $display("FAIL reset_bus[%0d]: got rdy=%b rv=%b rf=%b rd=%h want rdy=1 rv=0 rf=0 rd=0000",
                 d, o_rdy, o_rv, o_rf, o_rd);
      end
      checks++;
      if (o_en !== 1'b0 || o_wl !== 1'b0 || o_wh !== 1'b0 || o_addr !== 16'h0 || o_wd !== 16'h0) begin
        errors++;
        $display("FAIL reset_mem[%0d]: got en=%b wl=%b wh=%b addr=%h wd=%h want all 0",
                 d, o_en, o_wl, o_wh, o_addr, o_wd);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    sel = 0;
    @(negedge clk);
  endtask

  task automatic test_word_load;
    sel = 0;
    do_req(1'b0, 1'b0, 16'h1234, 16'h0);
    void'(model_apply(0, 1'b0, 1'b0, 16'h1234, 16'h0));
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL word_load_lat: got %0d want 2", lat); end
    checks++;
    if (rd !== 16'h1234) begin errors++; $display("FAIL word_load_rdata: got %h want 1234", rd); end
    checks++;
    if (flt !== 1'b0) begin errors++; $display("FAIL word_load_fault: got %b want 0", flt); end
    checks++;
    if (ra !== 1'b1) begin errors++; $display("FAIL word_load_ready: got %b want 1", ra); end
  endtask

  task automatic test_byte_load;
    logic [15:0] addrs [3];
    logic [15:0] exps  [3];
    addrs[0] = 16'h00FE; exps[0] = 16'hFFFE;
    addrs[1] = 16'h0081; exps[1] = 16'h0000;
    addrs[2] = 16'h00FF; exps[2] = 16'h0000;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 1'b1, addrs[i], 16'h0);
      void'(model_apply(0, 1'b0, 1'b1, addrs[i], 16'h0));
      checks++;
      if (rd !== exps[i] || lat !== 2 || flt !== 1'b0) begin
        errors++;
        $display("FAIL byte_load %h: got rd=%h lat=%0d flt=%b want rd=%h lat=2 flt=0",
                 addrs[i], rd, lat, flt, exps[i]);
      end
    end
  endtask

  task automatic test_byte_store;
    sel = 0;
    do_req(1'b1, 1'b1, 16'h0201, 16'h00A5);
    void'(model_apply(0, 1'b1, 1'b1, 16'h0201, 16'h00A5));
    checks++;
    if (stb_n !== 1 || lo !== 1'b0 || hi !== 1'b1) begin
      errors++;
      $display("FAIL byte_store_strobe: got n=%0d lo=%b hi=%b want n=1 lo=0 hi=1", stb_n, lo, hi);
    end
    checks++;
    if (wd !== 16'hA5A5) begin errors++; $display("FAIL byte_store_wdata: got %h want a5a5", wd); end
    checks++;
    if (rd !== 16'h0000 || lat !== 2) begin
      errors++; $display("FAIL byte_store_resp: got rd=%h lat=%0d want 0000 2", rd, lat);
    end
    do_req(1'b0, 1'b0, 16'h0200, 16'h0);
    void'(model_apply(0, 1'b0, 1'b0, 16'h0200, 16'h0));
    checks++;
    if (rd !== 16'hA500) begin errors++; $display("FAIL byte_store_reload: got %h want a500", rd); end
  endtask

  task automatic test_fault;
    sel = 0;
    do_req(1'b0, 1'b0, 16'h0003, 16'h0);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL fault_lat: got %0d want 1", lat); end
    checks++;
    if (flt !== 1'b1 || rd !== 16'h0) begin
      errors++; $display("FAIL fault_resp: got flt=%b rd=%h want 1 0000", flt, rd);
    end
    checks++;
    if (en_n !== 0) begin errors++; $display("FAIL fault_mem_en: got %0d cycles want 0", en_n); end
  endtask

  task automatic test_wait_store;
    sel = 1;
    do_req(1'b1, 1'b0, 16'h0400, 16'hBEEF);
    void'(model_apply(1, 1'b1, 1'b0, 16'h0400, 16'hBEEF));
    checks++;
    if (en_n !== 4) begin errors++; $display("FAIL wait_store_en: got %0d cycles want 4", en_n); end
    checks++;
    if (stb_n !== 1 || stb_k !== 4 || lo !== 1'b1 || hi !== 1'b1) begin
      errors++;
      $display("FAIL wait_store_strobe: got n=%0d at=%0d lo=%b hi=%b want n=1 at=4 lo=1 hi=1",
               stb_n, stb_k, lo, hi);
    end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL wait_store_lat: got %0d want 5", lat); end
    do_req(1'b0, 1'b0, 16'h0400, 16'h0);
    void'(model_apply(1, 1'b0, 1'b0, 16'h0400, 16'h0));
    checks++;
    if (rd !== 16'hBEEF || lat !== 5) begin
      errors++; $display("FAIL wait_store_reload: got rd=%h lat=%0d want beef 5", rd, lat);
    end
  endtask

  task automatic test_rst_mid(input int d);
    logic [15:0] exp;
    bit seen_rv, seen_stb;
    sel = d;
    t_write = 1'b1; t_byte = 1'b0; t_addr = 16'h0500; t_wdata = 16'h1357; t_valid = 1'b1;
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    checks++;
    if (o_en !== 1'b1) begin errors++; $display("FAIL rst_mid_access[%0d]: got en=%b want 1", d, o_en); end
    rst = 1'b1;
    #1;
    checks++;
    if (o_en !== 1'b0 || o_wl !== 1'b0 || o_wh !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop[%0d]: got en=%b wl=%b wh=%b want 0 0 0", d, o_en, o_wl, o_wh);
    end
    seen_rv = 0; seen_stb = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_rv) seen_rv = 1;
      if (o_wl || o_wh) seen_stb = 1;
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      if (o_rv) seen_rv = 1;
      if (o_wl || o_wh) seen_stb = 1;
      @(negedge clk);
    end
    checks++;
    if (seen_rv || seen_stb) begin
      errors++; $display("FAIL rst_mid_quiet[%0d]: got rv=%b stb=%b want 0 0", d, seen_rv, seen_stb);
    end
    checks++;
    if (o_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_ready[%0d]: got %b want 1", d, o_rdy); end
    do_req(1'b0, 1'b0, 16'h0500, 16'h0);
    exp = model_apply(d, 1'b0, 1'b0, 16'h0500, 16'h0);
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL rst_mid_unchanged[%0d]: got %h want %h", d, rd, exp); end
  endtask

  task automatic test_back_to_back;
    sel = 0;
    do_req(1'b1, 1'b0, 16'h0600, 16'hC0DE);
    void'(model_apply(0, 1'b1, 1'b0, 16'h0600, 16'hC0DE));
    checks++;
    if (ra !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", ra); end
    do_req(1'b0, 1'b0, 16'h0600, 16'h0);
    void'(model_apply(0, 1'b0, 1'b0, 16'h0600, 16'h0));
    checks++;
    if (rd !== 16'hC0DE || lat !== 2) begin
      errors++; $display("FAIL b2b_load: got rd=%h lat=%0d want c0de 2", rd, lat);
    end
  endtask

  task automatic test_random(input int d);
    logic        wr, by, ef;
    logic [15:0] a, dat, er, ewd;
    int          w;
    w = (d == 0) ? 0 : 3;
    sel = d;
    for (int n = 0; n < 30; n++) begin
      wr  = 1'($urandom);
      by  = 1'($urandom);
      a   = 16'h0300 + 16'($urandom_range(0, 31));
      dat = 16'($urandom);
      ef  = !by && a[0];
      do_req(wr, by, a, dat);
      er  = model_apply(d, wr, by, a, dat);
      ewd = by ? {dat[7:0], dat[7:0]} : dat;
      checks++;
      if (lat !== (ef ? 1 : 2 + w) || flt !== ef || rd !== er) begin
        errors++;
        $display("FAIL rnd_resp[%0d] wr=%b by=%b a=%h: got lat=%0d flt=%b rd=%h want %0d %b %h",
                 d, wr, by, a, lat, flt, rd, ef ? 1 : 2 + w, ef, er);
      end
      checks++;
      if (en_n !== (ef ? 0 : 1 + w) || stb_n !== ((wr && !ef) ? 1 : 0)) begin
        errors++;
        $display("FAIL rnd_mem[%0d] wr=%b by=%b a=%h: got en=%0d stb=%0d want %0d %0d",
                 d, wr, by, a, en_n, stb_n, ef ? 0 : 1 + w, (wr && !ef) ? 1 : 0);
      end
      if (stb_n == 1) begin
        checks++;
        if (lo !== (!by || !a[0]) || hi !== (!by || a[0]) || wd !== ewd || sa !== a ||
            stb_k !== 1 + w) begin
          errors++;
          $display("FAIL rnd_strobe[%0d] a=%h: got lo=%b hi=%b wd=%h addr=%h at=%0d want %b %b %h %h %0d",
                   d, a, lo, hi, wd, sa, stb_k, !by || !a[0], !by || a[0], ewd, a, 1 + w);
        end
      end
      checks++;
      if (ra !== 1'b1) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want 1", d, ra); end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32768; i++)
        refm[d][i] = 16'(i * 2);
    test_reset();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_fault();
    test_wait_store();
    test_rst_mid(0);
    test_rst_mid(1);
    test_back_to_back();
    test_random(0);
    test_random(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
